// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the CPU load/store path and a DMA
// requester. Grants are combinational in the request cycle. The CPU stalls
// whenever it requests and is not granted. DMA may lock the port for a burst of
// at most MAX_BURST beats. After the lock ends, a waiting CPU is served next.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ARB      | round-robin between CPU and DMA; last_owner breaks ties
// DMA_LOCK | DMA owns the port while it keeps requesting, CPU is held off
module dmem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_din,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_dout,
    input  logic              dma_req,
    input  logic              dma_last,
    input  logic [3:0]        dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_din,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_dout,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    typedef enum logic {
        ARB      = 1'b0,
        DMA_LOCK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_owner, last_owner_nxt;
    logic             rsel_cpu, rsel_dma;

    // Byte-lane and upper address bits never reach the word-addressed port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    // State register: arbitration state, burst beat count and tie-break owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            cnt        <= '0;
            last_owner <= OWNER_DMA;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Read-return steering: remember who issued a granted read last cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsel_cpu <= 1'b0;
            rsel_dma <= 1'b0;
        end else begin
            rsel_cpu <= cpu_gnt & ~|cpu_we;
            rsel_dma <= dma_gnt & ~|dma_we;
        end
    end

    // Next-state: enter lock on a non-final DMA beat, leave on last/limit/bubble
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        case (state)
            ARB: begin
                if (cpu_gnt) begin
                    last_owner_nxt = OWNER_CPU;
                end else if (dma_gnt) begin
                    last_owner_nxt = OWNER_DMA;
                    if (!dma_last) begin
                        state_nxt = DMA_LOCK;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DMA_LOCK: begin
                if (!dma_req || (dma_gnt && (dma_last || cnt == CNT_LAST))) begin
                    state_nxt      = ARB;
                    last_owner_nxt = OWNER_DMA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // Output decode: zero-latency grants, held low while reset is asserted
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst) begin
            case (state)
                ARB: begin
                    if (cpu_req && dma_req) begin
                        cpu_gnt = (last_owner == OWNER_DMA);
                        dma_gnt = (last_owner == OWNER_CPU);
                    end else begin
                        cpu_gnt = cpu_req;
                        dma_gnt = dma_req;
                    end
                end
                DMA_LOCK: begin
                    dma_gnt = dma_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    dma_gnt = 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory port drive: the granted requester steers the port; no grant, no write
    assign mem_en   = cpu_gnt | dma_gnt;
    assign mem_we   = cpu_gnt ? cpu_we : (dma_gnt ? dma_we : 4'b0000);
    assign mem_addr = dma_gnt ? dma_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
    assign mem_din  = dma_gnt ? dma_din : cpu_din;

    assign cpu_rvalid = rsel_cpu;
    assign dma_rvalid = rsel_dma;
    assign cpu_dout   = rsel_cpu ? mem_dout : 32'h0;
    assign dma_dout   = rsel_dma ? mem_dout : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a behavioural burst/round-robin model.
module tb_dmem_port_arbiter;

    localparam int ADDR_W    = 12;
    localparam int MAX_BURST = 8;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_din;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_dout;
    logic              dma_req;
    logic              dma_last;
    logic [3:0]        dma_we;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_dout;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_last(dma_last), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_din(dma_din), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model: burst bookkeeping in whole beats
    bit m_locked, m_last_dma, m_pend_cpu, m_pend_dma, m_fresh;
    int m_beats;
    bit e_cpu_gnt, e_dma_gnt, e_cpu_rv, e_dma_rv, e_en;
    logic [3:0]        e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_din;
    logic [31:0]       cur_mem_dout;

    task automatic model_reset();
        m_locked = 0; m_beats = 0; m_last_dma = 1;
        m_pend_cpu = 0; m_pend_dma = 0; m_fresh = 1;
    endtask

    task automatic model_eval();
        e_cpu_rv = m_pend_cpu;
        e_dma_rv = m_pend_dma;
        if (m_locked) begin
            e_cpu_gnt = 0; e_dma_gnt = dma_req;
        end else if (cpu_req && dma_req) begin
            e_cpu_gnt = m_last_dma; e_dma_gnt = !m_last_dma;
        end else begin
            e_cpu_gnt = cpu_req; e_dma_gnt = dma_req;
        end
        e_en   = e_cpu_gnt || e_dma_gnt;
        e_we   = e_cpu_gnt ? cpu_we : (e_dma_gnt ? dma_we : 4'h0);
        e_addr = e_cpu_gnt ? ADDR_W'(cpu_addr >> 2) : ADDR_W'(dma_addr >> 2);
        e_din  = e_cpu_gnt ? cpu_din : dma_din;
    endtask

    // apply the effect of the clock edge that followed the last evaluation
    task automatic model_commit();
        if (m_fresh) begin
            m_fresh = 0;
            return;
        end
        m_pend_cpu = e_cpu_gnt && (cpu_we == 4'h0);
        m_pend_dma = e_dma_gnt && (dma_we == 4'h0);
        if (e_cpu_gnt) m_last_dma = 0;
        if (e_dma_gnt) m_last_dma = 1;
        if (m_locked) begin
            if (!dma_req || dma_last || (m_beats + 1 >= MAX_BURST)) m_locked = 0;
            else m_beats++;
        end else if (e_dma_gnt && !dma_last) begin
            m_locked = 1; m_beats = 1;
        end
    endtask

    task automatic step_in(input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                           input logic dr, input logic dl, input logic [3:0] dw,
                           input logic [31:0] da);
        @(negedge clk);
        model_commit();
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = $urandom;
        dma_req = dr; dma_last = dl; dma_we = dw; dma_addr = da; dma_din = $urandom;
        mem_dout = $urandom;
        cur_mem_dout = mem_dout;
        #2;
        model_eval();
    endtask

    task automatic set_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        dma_req = 0; dma_last = 0; dma_we = 0; dma_addr = 0; dma_din = 0;
        mem_dout = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; set_idle();
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 4'hF;
        #2;
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %0b exp 0", cpu_gnt); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt got %0b exp 0", dma_gnt); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b exp 0", mem_en); end
        checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %h exp 0", mem_we); end
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {cpu_rvalid, dma_rvalid}); end
        @(negedge clk);
        set_idle(); rst = 1;
        model_reset();
    endtask

    task automatic test_cpu_read();
        step_in(1, 4'h0, 32'h1000_0008, 0, 0, 4'h0, 32'h0);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_cpu_gnt got %0b exp 1", cpu_gnt); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rd_mem_en got %0b exp 1", mem_en); end
        checks++; if (mem_addr !== 12'd2) begin errors++; $display("FAIL rd_mem_addr got %0d exp 2", mem_addr); end
        checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rd_mem_we got %h exp 0", mem_we); end
        step_in(0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0);
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_cpu_rvalid got %0b exp 1", cpu_rvalid); end
        checks++; if (cpu_dout !== cur_mem_dout) begin errors++; $display("FAIL rd_cpu_dout got %h exp %h", cpu_dout, cur_mem_dout); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dma_rvalid got %0b exp 0", dma_rvalid); end
    endtask

    task automatic test_contention();
        do_reset();
        step_in(1, 4'h0, 32'h40, 1, 0, 4'h0, 32'h80);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL cont0_cpu_gnt got %0b exp 1", cpu_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cont0_stall got %0b exp 0", cpu_stall); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL cont0_dma_gnt got %0b exp 0", dma_gnt); end
        step_in(1, 4'h0, 32'h40, 1, 1, 4'hF, 32'h80);
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL cont1_dma_gnt got %0b exp 1", dma_gnt); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cont1_stall got %0b exp 1", cpu_stall); end
        checks++; if (mem_addr !== 12'h020) begin errors++; $display("FAIL cont1_mem_addr got %h exp 020", mem_addr); end
        step_in(0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_burst4();
        step_in(1, 4'hF, 32'h100, 0, 0, 4'h0, 32'h0);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL b4_pre_cpu_gnt got %0b exp 1", cpu_gnt); end
        for (int k = 1; k <= 4; k++) begin
            step_in(1, 4'h0, 32'h100, 1, (k == 4), 4'hF, 32'h200 + 32'(4 * k));
            checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL b4_dma_gnt beat %0d got %0b exp 1", k, dma_gnt); end
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL b4_stall beat %0d got %0b exp 1", k, cpu_stall); end
            checks++; if (mem_we !== 4'hF) begin errors++; $display("FAIL b4_mem_we beat %0d got %h exp f", k, mem_we); end
        end
        step_in(1, 4'h0, 32'h100, 0, 0, 4'h0, 32'h0);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL b4_cpu_gnt_after got %0b exp 1", cpu_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL b4_stall_after got %0b exp 0", cpu_stall); end
    endtask

    task automatic test_burst_max();
        bit exp_cpu;
        for (int k = 1; k <= 20; k++) begin
            step_in(1, 4'h0, 32'h300, 1, 0, 4'hF, 32'h400 + 32'(4 * k));
            exp_cpu = (k % (MAX_BURST + 1) == 0);
            checks++; if (cpu_gnt !== exp_cpu) begin errors++; $display("FAIL bmax_cpu_gnt cyc %0d got %0b exp %0b", k, cpu_gnt, exp_cpu); end
            checks++; if (dma_gnt !== !exp_cpu) begin errors++; $display("FAIL bmax_dma_gnt cyc %0d got %0b exp %0b", k, dma_gnt, !exp_cpu); end
        end
        step_in(0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0);
        step_in(0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_bubble();
        bit req_p[5]  = '{1, 1, 0, 1, 0};
        bit last_p[5] = '{0, 0, 0, 1, 0};
        bit rv_p[5]   = '{0, 1, 1, 0, 1};
        for (int k = 0; k < 5; k++) begin
            step_in(0, 4'h0, 32'h0, req_p[k], last_p[k], 4'h0, 32'h800 + 32'(4 * k));
            checks++; if (dma_gnt !== req_p[k]) begin errors++; $display("FAIL bub_dma_gnt cyc %0d got %0b exp %0b", k, dma_gnt, req_p[k]); end
            checks++; if (dma_rvalid !== rv_p[k]) begin errors++; $display("FAIL bub_dma_rvalid cyc %0d got %0b exp %0b", k, dma_rvalid, rv_p[k]); end
            if (rv_p[k]) begin
                checks++; if (dma_dout !== cur_mem_dout) begin errors++; $display("FAIL bub_dma_dout cyc %0d got %h exp %h", k, dma_dout, cur_mem_dout); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 1; k <= 2; k++) begin
            step_in(0, 4'h0, 32'h0, 1, 0, 4'h0, 32'hA00 + 32'(4 * k));
            checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rmid_dma_gnt beat %0d got %0b exp 1", k, dma_gnt); end
        end
        @(negedge clk);
        dma_addr = 32'hA0C; cpu_req = 1; rst = 0;
        #2;
        checks++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin errors++; $display("FAIL rmid_gnts got %b exp 00", {cpu_gnt, dma_gnt}); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got %0b exp 0", dma_rvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rmid_mem_en got %0b exp 0", mem_en); end
        checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rmid_mem_we got %h exp 0", mem_we); end
        @(negedge clk);
        rst = 1;
        set_idle();
        model_reset();
        step_in(1, 4'h0, 32'h10, 1, 0, 4'h0, 32'h20);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_post_cpu_gnt got %0b exp 1", cpu_gnt); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rmid_post_dma_gnt got %0b exp 0", dma_gnt); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_post_rvalid got %0b exp 0", dma_rvalid); end
        step_in(1, 4'h0, 32'h10, 1, 1, 4'h0, 32'h20);
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rmid_post2_dma_gnt got %0b exp 1", dma_gnt); end
    endtask

    task automatic test_random();
        logic cr, dr, dl;
        logic [3:0] cw, dw;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            cr = ($urandom_range(0, 2) != 0);
            dr = ($urandom_range(0, 3) != 0);
            dl = ($urandom_range(0, 5) == 0);
            cw = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            dw = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            step_in(cr, cw, $urandom, dr, dl, dw, $urandom);
            checks++; if (cpu_gnt !== e_cpu_gnt) begin errors++; $display("FAIL rnd_cpu_gnt n %0d got %0b exp %0b", n, cpu_gnt, e_cpu_gnt); end
            checks++; if (dma_gnt !== e_dma_gnt) begin errors++; $display("FAIL rnd_dma_gnt n %0d got %0b exp %0b", n, dma_gnt, e_dma_gnt); end
            checks++; if (cpu_stall !== (cr && !e_cpu_gnt)) begin errors++; $display("FAIL rnd_stall n %0d got %0b exp %0b", n, cpu_stall, cr && !e_cpu_gnt); end
            checks++; if (cpu_rvalid !== e_cpu_rv) begin errors++; $display("FAIL rnd_cpu_rvalid n %0d got %0b exp %0b", n, cpu_rvalid, e_cpu_rv); end
            checks++; if (dma_rvalid !== e_dma_rv) begin errors++; $display("FAIL rnd_dma_rvalid n %0d got %0b exp %0b", n, dma_rvalid, e_dma_rv); end
            checks++; if (mem_en !== e_en) begin errors++; $display("FAIL rnd_mem_en n %0d got %0b exp %0b", n, mem_en, e_en); end
            checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rnd_mem_we n %0d got %h exp %h", n, mem_we, e_we); end
            if (e_en) begin
                checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_mem_addr n %0d got %h exp %h", n, mem_addr, e_addr); end
                checks++; if (mem_din !== e_din) begin errors++; $display("FAIL rnd_mem_din n %0d got %h exp %h", n, mem_din, e_din); end
            end
            if (e_cpu_rv) begin
                checks++; if (cpu_dout !== cur_mem_dout) begin errors++; $display("FAIL rnd_cpu_dout n %0d got %h exp %h", n, cpu_dout, cur_mem_dout); end
            end
            if (e_dma_rv) begin
                checks++; if (dma_dout !== cur_mem_dout) begin errors++; $display("FAIL rnd_dma_dout n %0d got %h exp %h", n, dma_dout, cur_mem_dout); end
            end
        end
    endtask

    initial begin
        rst = 0;
        set_idle();
        model_reset();
        test_reset();
        test_cpu_read();
        test_contention();
        test_burst4();
        test_burst_max();
        test_bubble();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
